run_seq_detector: RTL

Parametrised run-length sequence detector for a valid-qualified symbol stream. It recognises an ordered pattern of N symbols p0..pN-1, where each symbol after p0 may repeat. It asserts a level flag while the pattern is being held, emits a one-cycle pulse on each new detection, and keeps a saturating detection count. The pattern is loadable at run time. The block sits in the counting/detection path as the generalised replacement for the fixed 2-bit, 3-stage detector.

---
 rtl/run_seq_detector.sv | 135 +++++++++++++
 1 files changed

// File: rtl/run_seq_detector.sv
// rtl/run_seq_detector.sv - run-length ordered-pattern detector with pulse, level flag and saturating count
//
// Purpose:
//   Tracks how many symbols of the loaded pattern p0..pN-1 have been matched
//   so far (stage 0..N). Symbols after p0 may repeat in runs when
//   ALLOW_REPEAT=1. found is the level flag for stage==N. match pulses once
//   per entry into stage N. match_cnt counts those pulses and saturates.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   in_valid     qualifies in_sym
//   in_sym       input symbol, W bits
//   cfg_load     load cfg_pattern; also drops stage to 0 and discards in_sym
//   cfg_pattern  new pattern, p0 in the least significant W bits
//   cnt_clr      synchronous clear of match_cnt, wins over an increment
//   found        stage == N
//   match        registered one-cycle pulse on entry into stage N
//   match_cnt    saturating detection count
//   stage        matched-prefix length, for debug
module run_seq_detector #(
    parameter int W            = 2,
    parameter int N            = 3,
    parameter int CNT_W        = 8,
    parameter int ALLOW_REPEAT = 1,
    parameter logic [N*W-1:0] DEFAULT_PATTERN = {2'd3, 2'd2, 2'd1},
    localparam int SW = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [W-1:0]       in_sym,
    input  logic               cfg_load,
    input  logic [N*W-1:0]     cfg_pattern,
    input  logic               cnt_clr,
    output logic               found,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [SW-1:0]      stage
);

    logic [N*W-1:0]   pattern_q, pattern_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [W-1:0]     pat_sym [N];
    logic [W-1:0]     p_cur;     // symbol that would advance from the current stage
    logic [W-1:0]     p_prev;    // last matched symbol, used for run holding
    logic             cur_ok;    // stage_q in 1..N-1, so p_cur is meaningful
    logic             prev_ok;   // stage_q >= 2, so p_prev is meaningful
    logic [SW-1:0]    stage_next;

    // Unpack the pattern register into per-symbol slots.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pat_sym[i] = pattern_q[i*W +: W];
        end
    end

    // Select pk and pk-1 by comparing each slot index against the stage,
    // which avoids an out-of-range index when stage == N.
    always_comb begin
        p_cur  = '0;
        p_prev = '0;
        for (int i = 0; i < N; i++) begin
            if (SW'(i) == stage_q) begin
                p_cur = pat_sym[i];
            end
            if (SW'(i + 1) == stage_q) begin
                p_prev = pat_sym[i];
            end
        end
    end

    assign cur_ok  = (stage_q >= SW'(1)) && (stage_q < SW'(N));
    assign prev_ok = (ALLOW_REPEAT != 0) && (stage_q >= SW'(2));

    // Priority: restart on p0, then advance, then hold on a repeat, else drop.
    // The ordering decides the outcome when the pattern has duplicate symbols.
    always_comb begin
        stage_next = '0;
        if (in_sym == pat_sym[0]) begin
            stage_next = SW'(1);
        end else if (cur_ok && (in_sym == p_cur)) begin
            stage_next = stage_q + SW'(1);
        end else if (prev_ok && (in_sym == p_prev)) begin
            stage_next = stage_q;
        end else begin
            stage_next = '0;
        end
    end

    always_comb begin
        pattern_d = pattern_q;
        stage_d   = stage_q;
        match_d   = 1'b0;
        cnt_d     = cnt_q;

        if (cfg_load) begin
            // A reconfiguration restarts detection; the symbol on this edge is dropped.
            pattern_d = cfg_pattern;
            stage_d   = '0;
        end else if (in_valid) begin
            stage_d = stage_next;
            match_d = (stage_next == SW'(N)) && (stage_q != SW'(N));
        end

        if (cnt_clr) begin
            cnt_d = '0;
        end else if (match_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_q <= DEFAULT_PATTERN;
            stage_q   <= '0;
            match_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            stage_q   <= stage_d;
            match_q   <= match_d;
            cnt_q     <= cnt_d;
        end
    end

    assign found     = (stage_q == SW'(N));
    assign match     = match_q;
    assign match_cnt = cnt_q;
    assign stage     = stage_q;

endmodule
